// File: rtl/tx_zc_gen.sv
// Zadoff-Chu phase generator: one phase word per sample, integer recursion, no LUT.
// Latency: 2*NZC_W+2 cycles from the sampled start to the first out_valid, then one sample per cycle.
// Backpressure: with TX_ZC_GEN_BACKPRESSURE_EN the outputs hold while out_ready=0; otherwise out_ready is ignored.
//
// Optional feature macro: TX_ZC_GEN_BACKPRESSURE_EN (undefined: every RUN cycle is an accept).
//
// Ports:
//   sys_clk, rst             clock and asynchronous active-high reset
//   cfg_u / cfg_n_zc         root u and odd prime length N
//   cfg_start_idx / cfg_len  first index m0 and number of samples to emit
//   cfg_inv_2n               round(2^(PHASE_W+NZC_W) / 2N), phase scale for k
//   cfg_alpha_step           cyclic-shift phase increment per sample
//   start / abort            one-cycle control pulses
//   out_ready                consumer ready
//   busy / done              status: busy outside IDLE, done pulses once per completed run
//   out_valid/out_phase/out_index/out_last   sample stream
module tx_zc_gen #(
    parameter int PHASE_W = 16,
    parameter int NZC_W   = 12,
    parameter int LEN_W   = 12
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [NZC_W-1:0]         cfg_u,
    input  logic [NZC_W-1:0]         cfg_n_zc,
    input  logic [NZC_W-1:0]         cfg_start_idx,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [PHASE_W+NZC_W-1:0] cfg_inv_2n,
    input  logic [PHASE_W-1:0]       cfg_alpha_step,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    output logic [PHASE_W-1:0]       out_phase,
    output logic [NZC_W-1:0]         out_index,
    output logic                     out_last
);

    // Residues mod 2N need one bit more than N itself.
    localparam int MW     = NZC_W + 1;
    localparam int CNT_W  = $clog2(NZC_W + 1);
    localparam int INV_W  = PHASE_W + NZC_W;
    localparam int PROD_W = MW + INV_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_MUL2 = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NZC_W-1:0]   u_q, u_d;
    logic [NZC_W-1:0]   n_q, n_d;
    logic [NZC_W-1:0]   m_q, m_d;        // current sequence index (holds m0 during MUL1/MUL2)
    logic [LEN_W-1:0]   len_q, len_d;    // samples still to emit
    logic [INV_W-1:0]   inv_q, inv_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [PHASE_W-1:0] alpha_q, alpha_d;
    logic [MW-1:0]      k_q, k_d;        // u*m*(m+1) mod 2N
    logic [MW-1:0]      dlt_q, dlt_d;    // k(m+1)-k(m) mod 2N
    logic [MW-1:0]      t_q, t_d;        // m0*(m0+1) mod 2N
    logic [MW-1:0]      e_q, e_d;        // u*(m0+1) mod N
    logic [NZC_W-1:0]   sr_q, sr_d;      // multiplier bits, consumed MSB first
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MW-1:0]      two_n;
    logic [MW-1:0]      n_ext;
    logic [MW-1:0]      two_u;
    logic [MW-1:0]      mp1;
    logic [MW-1:0]      mp1_modn;
    logic               m_last;
    logic               accept;
    logic [PHASE_W-1:0] zc_ph;

    // (a + b) mod m for a, b < m: one conditional subtract keeps the result below m.
    function automatic logic [MW-1:0] mod_add(input logic [MW-1:0] a,
                                              input logic [MW-1:0] b,
                                              input logic [MW-1:0] m);
        logic [MW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[MW-1:0];
    endfunction

    // One MSB-first shift-add step: (2*acc + b*x) mod m, each half reduced separately.
    function automatic logic [MW-1:0] mac_step(input logic [MW-1:0] acc,
                                               input logic [MW-1:0] x,
                                               input logic          b,
                                               input logic [MW-1:0] m);
        logic [MW-1:0] dbl;
        dbl = mod_add(acc, acc, m);
        return mod_add(dbl, b ? x : '0, m);
    endfunction

    assign two_n    = {n_q, 1'b0};
    assign n_ext    = {1'b0, n_q};
    // u < N, so 2u is already a residue mod 2N.
    assign two_u    = {u_q, 1'b0};
    // m0 <= N-1, so m0+1 <= N < 2N needs no reduction mod 2N, only a wrap mod N.
    assign mp1      = {1'b0, m_q} + MW'(1);
    assign mp1_modn = (mp1 == n_ext) ? '0 : mp1;
    assign m_last   = (m_q == n_q - NZC_W'(1));

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = (state_q == S_RUN);
    assign out_last  = out_valid && (len_q == LEN_W'(1));
    assign out_index = out_valid ? m_q : '0;

    // ZC phase = k/(2N) of a turn; keep the PHASE_W bits just above the NZC_W fraction bits.
    assign zc_ph     = PHASE_W'((PROD_W'(k_q) * PROD_W'(inv_q)) >> NZC_W);
    assign out_phase = out_valid ? (alpha_q - zc_ph) : '0;

`ifdef TX_ZC_GEN_BACKPRESSURE_EN
    assign accept = out_valid && out_ready;
`else
    assign accept = out_valid;
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
`endif

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        n_d     = n_q;
        m_d     = m_q;
        len_d   = len_q;
        inv_d   = inv_q;
        step_d  = step_q;
        alpha_d = alpha_q;
        k_d     = k_q;
        dlt_d   = dlt_q;
        t_d     = t_q;
        e_d     = e_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    u_d     = cfg_u;
                    n_d     = cfg_n_zc;
                    m_d     = cfg_start_idx;
                    len_d   = cfg_len;
                    inv_d   = cfg_inv_2n;
                    step_d  = cfg_alpha_step;
                    alpha_d = '0;
                    k_d     = '0;
                    dlt_d   = '0;
                    t_d     = '0;
                    e_d     = '0;
                    sr_d    = cfg_start_idx;
                    cnt_d   = CNT_W'(NZC_W - 1);
                    state_d = (cfg_len == '0) ? S_DONE : S_MUL1;
                end
            end

            // t = m0 * (m0+1) mod 2N, one multiplier bit per cycle.
            S_MUL1: begin
                t_d  = mac_step(t_q, mp1, sr_q[NZC_W-1], two_n);
                sr_d = sr_q << 1;
                if (cnt_q == '0) begin
                    sr_d    = u_q;
                    cnt_d   = CNT_W'(NZC_W);
                    state_d = S_MUL2;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // NZC_W bit steps over u giving k0 = u*t mod 2N and e0 = u*(m0+1) mod N,
            // then one extra cycle forming d0 = 2*e0 (always < 2N, so no wrap).
            S_MUL2: begin
                if (cnt_q != '0) begin
                    k_d   = mac_step(k_q, t_q, sr_q[NZC_W-1], two_n);
                    e_d   = mac_step(e_q, mp1_modn, sr_q[NZC_W-1], n_ext);
                    sr_d  = sr_q << 1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    dlt_d   = mod_add(e_q, e_q, two_n);
                    state_d = S_RUN;
                end
            end

            // With N odd, k and d return to their m=0 values after N steps,
            // so only the index needs an explicit wrap.
            S_RUN: begin
                if (accept) begin
                    k_d     = mod_add(k_q, dlt_q, two_n);
                    dlt_d   = mod_add(dlt_q, two_u, two_n);
                    m_d     = m_last ? '0 : (m_q + NZC_W'(1));
                    alpha_d = alpha_q + step_q;
                    len_d   = len_q - 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle final accept.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            len_q   <= '0;
            inv_q   <= '0;
            step_q  <= '0;
            alpha_q <= '0;
            k_q     <= '0;
            dlt_q   <= '0;
            t_q     <= '0;
            e_q     <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            n_q     <= n_d;
            m_q     <= m_d;
            len_q   <= len_d;
            inv_q   <= inv_d;
            step_q  <= step_d;
            alpha_q <= alpha_d;
            k_q     <= k_d;
            dlt_q   <= dlt_d;
            t_q     <= t_d;
            e_q     <= e_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tx_zc_gen.sv
module tb_tx_zc_gen;

    localparam int PHASE_W = 16;
    localparam int NZC_W   = 12;
    localparam int LEN_W   = 12;
    localparam int EXP_LAT = 2 * NZC_W + 2;
    localparam longint PH_MASK = (longint'(1) << PHASE_W) - 1;

`ifdef TX_ZC_GEN_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic                     sys_clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NZC_W-1:0]         cfg_u = '0;
    logic [NZC_W-1:0]         cfg_n_zc = '0;
    logic [NZC_W-1:0]         cfg_start_idx = '0;
    logic [LEN_W-1:0]         cfg_len = '0;
    logic [PHASE_W+NZC_W-1:0] cfg_inv_2n = '0;
    logic [PHASE_W-1:0]       cfg_alpha_step = '0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     out_ready = 1'b1;
    logic                     busy;
    logic                     done;
    logic                     out_valid;
    logic [PHASE_W-1:0]       out_phase;
    logic [NZC_W-1:0]         out_index;
    logic                     out_last;

    typedef struct {
        logic [PHASE_W-1:0] phase;
        logic [NZC_W-1:0]   index;
        bit                 last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   acc_cnt = 0;
    bit   exp_done_next = 1'b0;
    int   stall_at = -1;
    int   stall_left = 0;
    bit   rnd_ready = 1'b0;
    int   primes[16] = '{3, 5, 7, 11, 13, 17, 19, 23, 31, 61, 127, 251, 509, 1021, 2039, 4093};

    always #5 sys_clk = ~sys_clk;

    tx_zc_gen #(.PHASE_W(PHASE_W), .NZC_W(NZC_W), .LEN_W(LEN_W)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .cfg_u          (cfg_u),
        .cfg_n_zc       (cfg_n_zc),
        .cfg_start_idx  (cfg_start_idx),
        .cfg_len        (cfg_len),
        .cfg_inv_2n     (cfg_inv_2n),
        .cfg_alpha_step (cfg_alpha_step),
        .start          (start),
        .abort          (abort),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .out_valid      (out_valid),
        .out_phase      (out_phase),
        .out_index      (out_index),
        .out_last       (out_last)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint inv_of(input int n);
        return ((longint'(1) << (PHASE_W + NZC_W)) + longint'(n)) / (2 * longint'(n));
    endfunction

    // Closed-form reference: every sample computed directly from its index.
    function automatic void model(input int u, input int n, input int m0, input int len, input int step);
        longint inv;
        longint m, k, zc, al;
        exp_t   e;
        inv = inv_of(n);
        for (int i = 0; i < len; i++) begin
            m  = (longint'(m0) + i) % n;
            k  = (longint'(u) * m * (m + 1)) % (2 * longint'(n));
            zc = ((k * inv) >> NZC_W) & PH_MASK;
            al = (longint'(i) * step) & PH_MASK;
            e.phase = PHASE_W'((al - zc) & PH_MASK);
            e.index = NZC_W'(m);
            e.last  = (i == len - 1);
            sb.push_back(e);
        end
    endfunction

    // Monitor: compare every presented sample with the scoreboard head, pop on accept.
    always @(negedge sys_clk) begin
        if (rst) begin
            exp_done_next = 1'b0;
        end else begin
            if (exp_done_next) begin
                check("done_after_last", longint'(done), 1);
                exp_done_next = 1'b0;
            end
            if (done) done_cnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("valid_with_empty_sb", longint'(out_valid), 0);
                end else begin
                    mon_e = sb[0];
                    check("phase", longint'(out_phase), longint'(mon_e.phase));
                    check("index", longint'(out_index), longint'(mon_e.index));
                    check("last",  longint'(out_last),  longint'(mon_e.last));
                    if (out_ready || !BP) begin
                        void'(sb.pop_front());
                        acc_cnt++;
                        if (mon_e.last) exp_done_next = 1'b1;
                    end
                end
            end
        end
    end

    // Consumer ready: directed stall, random, or always ready.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            if (stall_left > 0 && out_valid && acc_cnt == stall_at) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (rnd_ready) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic load_cfg(input int u, input int n, input int m0, input int len, input int step);
        cfg_u          = NZC_W'(u);
        cfg_n_zc       = NZC_W'(n);
        cfg_start_idx  = NZC_W'(m0);
        cfg_len        = LEN_W'(len);
        cfg_inv_2n     = (PHASE_W + NZC_W)'(inv_of(n));
        cfg_alpha_step = PHASE_W'(step);
    endtask

    task automatic scramble_cfg();
        cfg_u          = NZC_W'($urandom);
        cfg_n_zc       = NZC_W'($urandom);
        cfg_start_idx  = NZC_W'($urandom);
        cfg_len        = LEN_W'($urandom);
        cfg_inv_2n     = (PHASE_W + NZC_W)'($urandom);
        cfg_alpha_step = PHASE_W'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the run is back in IDLE.
    task automatic do_run(input int u, input int n, input int m0, input int len, input int step, input bit poke);
        int lat, cyc, d0;
        model(u, n, m0, len, step);
        acc_cnt = 0;
        load_cfg(u, n, m0, len, step);
        start = 1'b1;
        d0 = done_cnt;
        @(posedge sys_clk); #1;
        start = 1'b0;
        scramble_cfg();
        if (len == 0) begin
            check("len0_done", longint'(done), 1);
            check("len0_valid", longint'(out_valid), 0);
        end else begin
            lat = 1;
            while (!out_valid && lat < 4 * EXP_LAT) begin
                @(posedge sys_clk); #1;
                lat++;
            end
            check("latency", longint'(lat), longint'(EXP_LAT));
        end
        if (poke) begin
            @(posedge sys_clk); #1;
            start = 1'b1;
            @(posedge sys_clk); #1;
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        check("done_pulses", longint'(done_cnt - d0), 1);
        check("sb_drained", longint'(sb.size()), 0);
        check("idle_after_done", longint'(busy), 0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int d0, cyc, u, n, m0, len;

        // Reset state.
        #12;
        check("rst_busy",  longint'(busy), 0);
        check("rst_done",  longint'(done), 0);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_phase", longint'(out_phase), 0);
        check("rst_index", longint'(out_index), 0);
        check("rst_last",  longint'(out_last), 0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        @(posedge sys_clk); #1;

        // Full period N=7, then start-index wrap, then cyclic shift.
        do_run(1, 7, 0, 7, 0, 1'b0);
        do_run(1, 7, 5, 4, 0, 1'b0);
        do_run(1, 7, 0, 3, 5461, 1'b0);

        // Consumer stall on the second sample (only takes effect with backpressure).
        stall_at = 1;
        stall_left = 3;
        do_run(1, 7, 0, 7, 0, 1'b0);
        stall_left = 0;
        stall_at = -1;

        // Abort during the third RUN cycle.
        model(1, 7, 0, 7, 0);
        acc_cnt = 0;
        load_cfg(1, 7, 0, 7, 0);
        start = 1'b1;
        d0 = done_cnt;
        @(posedge sys_clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        check("abort_reached_run", longint'(out_valid), 1);
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        abort = 1'b1;
        @(posedge sys_clk); #1;
        abort = 1'b0;
        check("abort_busy",  longint'(busy), 0);
        check("abort_valid", longint'(out_valid), 0);
        repeat (4) begin
            @(posedge sys_clk); #1;
        end
        check("abort_no_done", longint'(done_cnt - d0), 0);
        sb.delete();
        do_run(1, 7, 0, 7, 0, 1'b0);

        // Zero-length run.
        do_run(1, 7, 0, 0, 0, 1'b0);

        // Start pulse and cfg changes while busy are ignored.
        do_run(3, 11, 4, 15, 1234, 1'b1);

        // Asynchronous reset mid-run.
        model(2, 13, 3, 20, 777);
        acc_cnt = 0;
        load_cfg(2, 13, 3, 20, 777);
        start = 1'b1;
        d0 = done_cnt;
        @(posedge sys_clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        @(posedge sys_clk); #1;
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy",  longint'(busy), 0);
        check("arst_done",  longint'(done), 0);
        check("arst_valid", longint'(out_valid), 0);
        check("arst_phase", longint'(out_phase), 0);
        check("arst_index", longint'(out_index), 0);
        check("arst_last",  longint'(out_last), 0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        sb.delete();
        acc_cnt = 0;
        repeat (3) begin
            @(posedge sys_clk); #1;
        end
        check("arst_no_done", longint'(done_cnt - d0), 0);

        // Randomized runs, random consumer readiness.
        rnd_ready = 1'b1;
        for (int r = 0; r < 24; r++) begin
            n  = primes[$urandom_range(0, 15)];
            u  = $urandom_range(1, n - 1);
            m0 = $urandom_range(0, n - 1);
            if ($urandom_range(0, 1) == 1) m0 = n - 1 - $urandom_range(0, (n > 10) ? 10 : n - 1);
            len = $urandom_range(1, 40);
            do_run(u, n, m0, len, $urandom_range(0, 65535), ($urandom_range(0, 3) == 0));
        end
        rnd_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
